// File: rtl/pipe_pkg.sv
// pipe_pkg: shared codes for the pipeline hazard controller.
package pipe_pkg;
  typedef enum logic [1:0] {
    LDST_NONE  = 2'b00,
    LDST_LOAD  = 2'b01,
    LDST_STORE = 2'b10,
    LDST_RSV   = 2'b11
  } ldst_e;
  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LDWAIT  = 2'd1,
    S_MEMWAIT = 2'd2
  } state_e;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;
  localparam logic [9:0] CNT_MAX = 10'd1023;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: selects one E-stage operand source; a load in M has no ALU result to forward.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [2:0] i_rs,
  input  logic       i_m_wr_en,
  input  logic [1:0] i_m_ldst,
  input  logic [2:0] i_m_wr_reg,
  input  logic       i_w_wr_en,
  input  logic [2:0] i_w_wr_reg,
  output logic [1:0] o_fwd
);
  assign o_fwd = (i_m_wr_en && i_m_ldst != LDST_LOAD && i_m_wr_reg == i_rs) ? FWD_M :
                 (i_w_wr_en && i_w_wr_reg == i_rs) ? FWD_W : FWD_RF;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/forward control for a 5-stage pipeline with a stall cycle counter.
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_d_rs1,
  input  logic [2:0] i_d_rs2,
  input  logic       i_d_use1,
  input  logic       i_d_use2,
  input  logic [2:0] i_e_rs1,
  input  logic [2:0] i_e_rs2,
  input  logic       i_e_wr_en,
  input  logic [2:0] i_e_wr_reg,
  input  logic [1:0] i_e_ldst_en,
  input  logic       i_m_wr_en,
  input  logic [2:0] i_m_wr_reg,
  input  logic [1:0] i_m_ldst_en,
  input  logic       i_w_wr_en,
  input  logic [2:0] i_w_wr_reg,
  input  logic       i_br_taken,
  input  logic       i_mem_ready,
  input  logic       i_cnt_clr,
  output logic       o_mem_req,
  output logic       o_stall_fd,
  output logic       o_flush_fd,
  output logic       o_bubble_de,
  output logic       o_stall_em,
  output logic       o_bubble_mw,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic [9:0] o_stall_cnt
);
  state_e     r_state, w_next;
  logic [9:0] r_cnt;
  logic       w_mem_op, w_freeze, w_hit;
  logic [1:0] w_fwd_a, w_fwd_b;

  fwd_unit u_fwd_a (
    .i_rs(i_e_rs1), .i_m_wr_en(i_m_wr_en), .i_m_ldst(i_m_ldst_en), .i_m_wr_reg(i_m_wr_reg),
    .i_w_wr_en(i_w_wr_en), .i_w_wr_reg(i_w_wr_reg), .o_fwd(w_fwd_a)
  );
  fwd_unit u_fwd_b (
    .i_rs(i_e_rs2), .i_m_wr_en(i_m_wr_en), .i_m_ldst(i_m_ldst_en), .i_m_wr_reg(i_m_wr_reg),
    .i_w_wr_en(i_w_wr_en), .i_w_wr_reg(i_w_wr_reg), .o_fwd(w_fwd_b)
  );

  assign w_mem_op = i_m_ldst_en == LDST_LOAD || i_m_ldst_en == LDST_STORE;
  assign w_hit = i_e_ldst_en == LDST_LOAD && i_e_wr_en &&
                 ((i_d_use1 && i_e_wr_reg == i_d_rs1) || (i_d_use2 && i_e_wr_reg == i_d_rs2));
  // The load held in M during LDWAIT still needs its memory access, so only MEMWAIT forces the request.
  assign o_mem_req = i_rst_n && (r_state == S_MEMWAIT || w_mem_op);
  assign w_freeze = o_mem_req && !i_mem_ready;
  assign o_fwd_a = i_rst_n ? w_fwd_a : FWD_RF;
  assign o_fwd_b = i_rst_n ? w_fwd_b : FWD_RF;
  assign o_stall_cnt = r_cnt;

  always_comb begin
    o_stall_fd  = 1'b0;
    o_flush_fd  = 1'b0;
    o_bubble_de = 1'b0;
    o_stall_em  = 1'b0;
    o_bubble_mw = 1'b0;
    w_next      = S_RUN;
    if (!i_rst_n) begin
      w_next = S_RUN;
    end else if (w_freeze) begin
      o_stall_fd  = 1'b1;
      o_stall_em  = 1'b1;
      o_bubble_mw = 1'b1;
      w_next      = (r_state == S_LDWAIT) ? S_LDWAIT : S_MEMWAIT;
    end else if (i_br_taken) begin
      o_flush_fd  = 1'b1;
      o_bubble_de = 1'b1;
    end else if (r_state == S_LDWAIT) begin
      o_stall_fd  = 1'b1;
      o_bubble_de = 1'b1;
    end else if (w_hit) begin
      o_stall_fd  = 1'b1;
      o_bubble_de = 1'b1;
      w_next      = S_LDWAIT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 10'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= i_cnt_clr ? 10'd0 : (o_stall_fd && r_cnt != CNT_MAX) ? r_cnt + 10'd1 : r_cnt;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus against a rule-level model plus literal spot checks.
module tb_pipe_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [2:0] d_rs1, d_rs2, e_rs1, e_rs2, e_wr_reg, m_wr_reg, w_wr_reg;
  logic       d_use1, d_use2, e_wr_en, m_wr_en, w_wr_en, br_taken, mem_ready, cnt_clr;
  logic [1:0] e_ldst_en, m_ldst_en;
  logic       mem_req, stall_fd, flush_fd, bubble_de, stall_em, bubble_mw;
  logic [1:0] fwd_a, fwd_b;
  logic [9:0] stall_cnt;
  int checks = 0, errors = 0;

  pipe_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_d_rs1(d_rs1), .i_d_rs2(d_rs2), .i_d_use1(d_use1),
    .i_d_use2(d_use2), .i_e_rs1(e_rs1), .i_e_rs2(e_rs2), .i_e_wr_en(e_wr_en),
    .i_e_wr_reg(e_wr_reg), .i_e_ldst_en(e_ldst_en), .i_m_wr_en(m_wr_en), .i_m_wr_reg(m_wr_reg),
    .i_m_ldst_en(m_ldst_en), .i_w_wr_en(w_wr_en), .i_w_wr_reg(w_wr_reg), .i_br_taken(br_taken),
    .i_mem_ready(mem_ready), .i_cnt_clr(cnt_clr), .o_mem_req(mem_req), .o_stall_fd(stall_fd),
    .o_flush_fd(flush_fd), .o_bubble_de(bubble_de), .o_stall_em(stall_em),
    .o_bubble_mw(bubble_mw), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: outstanding memory wait, owed second load-use bubble, stall count
  int md_wait = 0, md_ld2 = 0, md_cnt = 0;
  int nx_wait = 0, nx_ld2 = 0, x_stall = 0, x_clr = 0;

  function automatic int fwd_exp(input int rs, input int men, input int mld, input int mreg,
                                 input int wen, input int wreg);
    if (men != 0 && mld != 1 && mreg == rs) return 1;
    if (wen != 0 && wreg == rs) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    int req, frz, hit, s_fd, fl, bde, sem, bmw;
    req = 0; frz = 0; s_fd = 0; fl = 0; bde = 0; sem = 0; bmw = 0;
    nx_wait = 0; nx_ld2 = 0;
    hit = (e_ldst_en == 2'd1 && e_wr_en && ((d_use1 && e_wr_reg == d_rs1) || (d_use2 && e_wr_reg == d_rs2))) ? 1 : 0;
    if (rst_n) begin
      req = (md_wait != 0 || m_ldst_en == 2'd1 || m_ldst_en == 2'd2) ? 1 : 0;
      frz = (req != 0 && !mem_ready) ? 1 : 0;
      if (frz != 0) begin
        s_fd = 1; sem = 1; bmw = 1; nx_ld2 = md_ld2; nx_wait = (md_ld2 == 0) ? 1 : 0;
      end else if (br_taken) begin
        fl = 1; bde = 1;
      end else if (md_ld2 != 0) begin
        s_fd = 1; bde = 1;
      end else if (hit != 0) begin
        s_fd = 1; bde = 1; nx_ld2 = 1;
      end
    end
    x_stall = s_fd; x_clr = cnt_clr;
    chk("mem_req", mem_req, req);
    chk("stall_fd", stall_fd, s_fd);
    chk("flush_fd", flush_fd, fl);
    chk("bubble_de", bubble_de, bde);
    chk("stall_em", stall_em, sem);
    chk("bubble_mw", bubble_mw, bmw);
    chk("fwd_a", fwd_a, rst_n ? fwd_exp(e_rs1, m_wr_en, m_ldst_en, m_wr_reg, w_wr_en, w_wr_reg) : 0);
    chk("fwd_b", fwd_b, rst_n ? fwd_exp(e_rs2, m_wr_en, m_ldst_en, m_wr_reg, w_wr_en, w_wr_reg) : 0);
    chk("stall_cnt", stall_cnt, md_cnt);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_wait <= 0; md_ld2 <= 0; md_cnt <= 0;
    end else begin
      md_wait <= nx_wait; md_ld2 <= nx_ld2;
      md_cnt <= (x_clr != 0) ? 0 : (x_stall != 0 && md_cnt < 1023) ? md_cnt + 1 : md_cnt;
    end
  end

  task automatic idle();
    d_rs1 = 0; d_rs2 = 0; d_use1 = 0; d_use2 = 0; e_rs1 = 0; e_rs2 = 0; e_wr_en = 0;
    e_wr_reg = 0; e_ldst_en = 0; m_wr_en = 0; m_wr_reg = 0; m_ldst_en = 0; w_wr_en = 0;
    w_wr_reg = 0; br_taken = 0; mem_ready = 1; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_hit();
    e_ldst_en = 2'd1; e_wr_en = 1; e_wr_reg = 3; d_rs1 = 3; d_use1 = 1;
  endtask

  typedef struct { int rs1, rs2, men, mld, mreg, wen, wreg, ea, eb; } fvec_t;
  fvec_t fv[5] = '{
    '{5, 5, 1, 0, 5, 1, 5, 1, 1},
    '{5, 5, 1, 1, 5, 1, 5, 2, 2},
    '{5, 2, 1, 3, 5, 1, 2, 1, 2},
    '{5, 2, 0, 0, 5, 1, 5, 2, 0},
    '{0, 7, 1, 2, 7, 1, 7, 0, 1}
  };

  initial begin
    idle();
    m_ldst_en = 2'd2;
    #1;
    chk("rst mem_req", mem_req, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    tick(); tick();
    rst_n = 1; m_ldst_en = 0;
    #1 chk("post-rst stall_fd", stall_fd, 0);
    tick();
    ld_hit();
    #1 chk("lu1 stall_fd", stall_fd, 1);
    chk("lu1 bubble_de", bubble_de, 1);
    tick();
    idle(); m_ldst_en = 2'd1; m_wr_en = 1; m_wr_reg = 3;
    #1 chk("lu2 stall_fd", stall_fd, 1);
    chk("lu2 bubble_de", bubble_de, 1);
    chk("lu2 mem_req", mem_req, 1);
    tick();
    idle();
    #1 chk("lu done stall_fd", stall_fd, 0);
    chk("lu stall_cnt", stall_cnt, 2);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    #1 chk("clr stall_cnt", stall_cnt, 0);
    m_ldst_en = 2'd2;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1 chk("mw mem_req", mem_req, 1);
      chk("mw stall_em", stall_em, (i < 3) ? 1 : 0);
      chk("mw bubble_mw", bubble_mw, (i < 3) ? 1 : 0);
      tick();
    end
    idle();
    #1 chk("mw run mem_req", mem_req, 0);
    chk("mw stall_cnt", stall_cnt, 3);
    tick();
    ld_hit(); br_taken = 1;
    #1 chk("br flush_fd", flush_fd, 1);
    chk("br bubble_de", bubble_de, 1);
    chk("br stall_fd", stall_fd, 0);
    tick();
    idle();
    #1 chk("br no ldwait", stall_fd, 0);
    ld_hit();
    tick();
    idle(); m_ldst_en = 2'd1; mem_ready = 0;
    #1 chk("ldw frz stall_em", stall_em, 1);
    chk("ldw frz bubble_de", bubble_de, 0);
    tick();
    mem_ready = 1;
    #1 chk("ldw resume bubble_de", bubble_de, 1);
    tick();
    idle();
    #1 chk("ldw done stall_fd", stall_fd, 0);
    foreach (fv[i]) begin
      e_rs1 = fv[i].rs1[2:0]; e_rs2 = fv[i].rs2[2:0]; m_wr_en = fv[i].men[0];
      m_ldst_en = fv[i].mld[1:0]; m_wr_reg = fv[i].mreg[2:0]; w_wr_en = fv[i].wen[0];
      w_wr_reg = fv[i].wreg[2:0];
      #1 chk("vec fwd_a", fwd_a, fv[i].ea);
      chk("vec fwd_b", fwd_b, fv[i].eb);
      tick();
    end
    idle();
    tick();
    m_ldst_en = 2'd2; mem_ready = 0;
    tick();
    m_ldst_en = 0;
    #1 chk("memwait mem_req", mem_req, 1);
    rst_n = 0;
    #1 chk("rst mw mem_req", mem_req, 0);
    chk("rst mw stall_em", stall_em, 0);
    chk("rst mw stall_cnt", stall_cnt, 0);
    tick();
    rst_n = 1; mem_ready = 1;
    #1 chk("rel mem_req", mem_req, 0);
    m_ldst_en = 2'd1;
    #1 chk("rel mem_req ld", mem_req, 1);
    idle();
    ld_hit();
    tick();
    idle();
    rst_n = 0;
    #1 chk("rst ldw stall_fd", stall_fd, 0);
    chk("rst ldw bubble_de", bubble_de, 0);
    tick();
    rst_n = 1;
    #1 chk("rel ldw stall_fd", stall_fd, 0);
    m_ldst_en = 2'd2; mem_ready = 0;
    repeat (1100) tick();
    chk("sat stall_cnt", stall_cnt, 1023);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    #1 chk("sat clr stall_cnt", stall_cnt, 0);
    idle();
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
